// File: rtl/gerador_sequencia.sv
// rtl/gerador_sequencia.sv - serializes an 8-bit word MSB first, repeated back to back
// The bit register is loaded on the same edge that accepts start, so data leads the state by no cycle.
module gerador_sequencia #(
    parameter int REP_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                setar_palavra,
    input  logic [7:0]          palavra,
    input  logic                start,
    input  logic [REP_BITS-1:0] repeticoes,
    input  logic                pausa,
    input  logic                cancelar,
    output logic                bit_out,
    output logic                bit_valido,
    output logic                ocupado,
    output logic                concluido
);

    typedef enum logic [1:0] {OCIOSO, ENVIANDO, FIM} estado_t;

    estado_t             estado, prox_estado;
    logic [7:0]          palavra_reg, palavra_d;
    logic [2:0]          indice, indice_d;
    logic [REP_BITS-1:0] restantes, restantes_d;
    logic                bit_out_d, bit_valido_d, ocupado_d, concluido_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    // restantes reaches zero only after bit 0 of the last copy has been sent
    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO: begin
                if (!setar_palavra && start) begin
                    prox_estado = ENVIANDO;
                end
            end
            ENVIANDO: begin
                if (cancelar) begin
                    prox_estado = OCIOSO;
                end else if (restantes == '0) begin
                    prox_estado = FIM;
                end
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    always_comb begin
        palavra_d    = palavra_reg;
        indice_d     = indice;
        restantes_d  = restantes;
        bit_out_d    = bit_out;
        bit_valido_d = 1'b0;
        ocupado_d    = (prox_estado == ENVIANDO);
        concluido_d  = (prox_estado == FIM);
        case (estado)
            OCIOSO: begin
                if (setar_palavra) begin
                    palavra_d = palavra;
                end else if (start) begin
                    bit_out_d    = palavra_reg[7];
                    bit_valido_d = 1'b1;
                    indice_d     = 3'd6;
                    restantes_d  = (repeticoes == '0) ? REP_BITS'(1) : repeticoes;
                end
            end
            ENVIANDO: begin
                if (!cancelar && !pausa && restantes != '0) begin
                    bit_out_d    = palavra_reg[indice];
                    bit_valido_d = 1'b1;
                    indice_d     = indice - 3'd1;
                    if (indice == 3'd0) begin
                        restantes_d = restantes - REP_BITS'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            palavra_reg <= 8'h00;
            indice      <= 3'd7;
            restantes   <= '0;
            bit_out     <= 1'b0;
            bit_valido  <= 1'b0;
            ocupado     <= 1'b0;
            concluido   <= 1'b0;
        end else begin
            palavra_reg <= palavra_d;
            indice      <= indice_d;
            restantes   <= restantes_d;
            bit_out     <= bit_out_d;
            bit_valido  <= bit_valido_d;
            ocupado     <= ocupado_d;
            concluido   <= concluido_d;
        end
    end

endmodule

// File: doc/gerador_sequencia.md
GERADOR_SEQUENCIA -- requirements
Module: gerador_sequencia

Interface
REQ-001 Parameter: REP_BITS, default 4, width of the repetition-count input.
REQ-002 Single clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: setar_palavra  input  1  load request for palavra.
REQ-006 Port: palavra  input  8  word to be transmitted.
REQ-007 Port: start  input  1  begin transmission request.
REQ-008 Port: repeticoes  input  REP_BITS  number of back-to-back word copies to send.
REQ-009 Port: pausa  input  1  stall request from the consumer.
REQ-010 Port: cancelar  input  1  abort the current transmission.
REQ-011 Port: bit_out  output  1  serial data, registered.
REQ-012 Port: bit_valido  output  1  bit_out carries a valid bit this cycle, registered.
REQ-013 Port: ocupado  output  1  transmission in progress, registered.
REQ-014 Port: concluido  output  1  one-cycle completion pulse, registered.

Function
REQ-015 The block SHALL hold an 8-bit word register, a 3-bit bit index, a REP_BITS-wide remaining-word counter and a state machine with states OCIOSO, ENVIANDO and FIM.
REQ-016 In OCIOSO, setar_palavra=1 SHALL load palavra into the word register on that edge.
REQ-017 In OCIOSO, setar_palavra=1 SHALL take priority over start; a start in the same cycle is ignored.
REQ-018 In OCIOSO, start=1 with setar_palavra=0 SHALL capture max(repeticoes,1) as the word count, set the bit index to 7 and enter ENVIANDO.
REQ-019 A repeticoes value of 0 SHALL be treated as 1.
REQ-020 Latency: the first bit SHALL appear on the cycle after start is sampled.
REQ-021 In ENVIANDO, each cycle with pausa=0 SHALL drive bit_out = word[index] with bit_valido=1.
REQ-022 Bits SHALL be sent MSB first, so that a left-shifting receiver holds the word after 8 valid bits.
REQ-023 After each valid bit, the bit index SHALL decrement.
REQ-024 In ENVIANDO, a cycle with pausa=1 SHALL drive bit_valido=0, hold bit_out at its previous value and leave the index and counter unchanged.
REQ-025 After bit 0 of a word, if words remain, the index SHALL wrap to 7 and the next copy SHALL start on the immediately following cycle, with no gap.
REQ-026 After bit 0 of the last word, the block SHALL enter FIM.
REQ-027 FIM SHALL last exactly one cycle with concluido=1, bit_valido=0 and ocupado=0, then return to OCIOSO.
REQ-028 ocupado SHALL be 1 exactly in the cycles where the state is ENVIANDO.
REQ-029 In ENVIANDO, cancelar=1 SHALL return the block to OCIOSO on the next edge with bit_valido=0 and without a concluido pulse.
REQ-030 cancelar SHALL take priority over pausa.
REQ-031 In OCIOSO, cancelar SHALL have no effect.
REQ-032 setar_palavra and start SHALL be ignored in ENVIANDO and FIM; the word register stays unchanged.
REQ-033 In OCIOSO, bit_valido and concluido SHALL be 0 and bit_out SHALL hold its last value.

Reset
REQ-034 rst=1 SHALL immediately force state OCIOSO, word register 8'h00, index 7, counter 0, bit_out=0, bit_valido=0, ocupado=0 and concluido=0, independent of clk.
REQ-035 A reset asserted mid-transmission SHALL abort it without a concluido pulse.
REQ-036 After rst is released, the word register SHALL be reloaded before a meaningful transmission.

Verification
REQ-037 Scenario: load 8'hA5, start with repeticoes=1 -> bit_out 1,0,1,0,0,1,0,1 with bit_valido=1 on cycles 1-8 after start, then concluido=1 for one cycle on cycle 9.
REQ-038 Scenario: load 8'h3C, repeticoes=3 -> 24 consecutive valid bits (three copies of 0,0,1,1,1,1,0,0) with ocupado=1 throughout, then a single concluido pulse.
REQ-039 Scenario: load 8'hF0, repeticoes=0, pausa=1 for 2 cycles after the 3rd bit -> exactly 8 valid bits over 10 cycles; bit_out is held during the pause; concluido follows.
REQ-040 Scenario: cancelar after the 4th bit of 8'h81 -> bit_valido=0 and ocupado=0 on the next cycle, with no concluido.
REQ-041 Scenario: setar_palavra with 8'h00 and start in the same cycle, and a second setar_palavra during ENVIANDO -> start is ignored in the first case and the word register is unchanged in the second.
REQ-042 Scenario: rst pulsed between clock edges during ENVIANDO, with bit_out, bit_valido, ocupado and concluido otherwise nonzero -> all outputs are 0 immediately; loopback of 8'h5A into the existing sequence detector then raises its encontrado flag one cycle after the 8th valid bit.
